// File: rtl/ajuste_valor_hora.sv
// Time-of-day field adjuster: BCD up/down stepping of hora/min/seg from buttons, with preload.
// Optional press-and-hold auto-repeat is built only when AUTO_REPEAT_EN is defined.
module ajuste_valor_hora #(
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_hora,
    input  logic        a_min,
    input  logic        a_seg,
    input  logic        btn_arriba,
    input  logic        btn_abajo,
    input  logic        cargar,
    input  logic [23:0] dato_in,
    output logic [7:0]  hora_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  seg_bcd,
    output logic        escribir
);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HORA = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEG  = 2'd3;

    // Out-of-range or non-BCD inputs snap to 00 going up and to the maximum going down.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= vmax)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v > vmax || v == 8'h00)
            r = vmax;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    logic [7:0] r_hora, r_min, r_seg;
    logic       r_escribir;
    logic       r_arr_prev, r_aba_prev;
    logic       r_armed;

    logic [1:0] w_sel;
    logic       w_one;
    logic       w_rise;
    logic       w_press;
    logic       w_step;
    logic [7:0] w_hora_nx, w_min_nx, w_seg_nx;

    always_comb begin
        w_sel = SEL_NONE;
        if (a_hora)
            w_sel = SEL_HORA;
        else if (a_min)
            w_sel = SEL_MIN;
        else if (a_seg)
            w_sel = SEL_SEG;
    end

    // r_armed stays low after reset until both buttons are seen released, so a held button cannot step.
    assign w_one   = btn_arriba ^ btn_abajo;
    assign w_rise  = w_one & r_armed & (btn_arriba ? ~r_arr_prev : ~r_aba_prev);
    assign w_press = w_rise & (w_sel != SEL_NONE) & ~cargar;

    assign w_hora_nx = btn_arriba ? bcd_inc(r_hora, 8'h23) : bcd_dec(r_hora, 8'h23);
    assign w_min_nx  = btn_arriba ? bcd_inc(r_min,  8'h59) : bcd_dec(r_min,  8'h59);
    assign w_seg_nx  = btn_arriba ? bcd_inc(r_seg,  8'h59) : bcd_dec(r_seg,  8'h59);

`ifdef AUTO_REPEAT_EN
    // state   | meaning
    // IDLE    | waiting for a fresh press
    // ESPERA  | button held, counting HOLD_CYCLES before repeating
    // REPITE  | button still held, one step every REPEAT_CYCLES
    typedef enum logic [1:0] {ST_IDLE, ST_ESPERA, ST_REPITE} state_t;

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int          CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [1:0]       r_sel;

    logic w_sel_chg;
    logic w_keep;
    logic w_rep;

    assign w_sel_chg = (w_sel != r_sel);
    assign w_keep    = (r_state != ST_IDLE) & w_one & ~w_sel_chg & (w_sel != SEL_NONE)
                       & (btn_arriba == r_dir) & ~cargar;
    // The end of the hold time is itself the first repeat step.
    assign w_rep     = w_keep & (((r_state == ST_ESPERA) && (r_cnt == HOLD_LAST)) ||
                                 ((r_state == ST_REPITE) && (r_cnt == REP_LAST)));
    assign w_step    = w_press | w_rep;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_sel   <= SEL_NONE;
        end else begin
            r_sel <= w_sel;
            if (w_press && !w_sel_chg) begin
                r_state <= ST_ESPERA;
                r_cnt   <= '0;
                r_dir   <= btn_arriba;
            end else if (!w_keep) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_ESPERA: begin
                        if (r_cnt == HOLD_LAST) begin
                            r_state <= ST_REPITE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
                        end
                    end
                    ST_REPITE: begin
                        if (r_cnt == REP_LAST)
                            r_cnt <= '0;
                        else
                            r_cnt <= (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end
`else
    assign w_step = w_press;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hora     <= 8'h00;
            r_min      <= 8'h00;
            r_seg      <= 8'h00;
            r_escribir <= 1'b0;
            r_arr_prev <= 1'b0;
            r_aba_prev <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_arr_prev <= btn_arriba;
            r_aba_prev <= btn_abajo;
            r_armed    <= r_armed | (~btn_arriba & ~btn_abajo);
            r_escribir <= cargar | w_step;
            if (cargar) begin
                r_hora <= dato_in[23:16];
                r_min  <= dato_in[15:8];
                r_seg  <= dato_in[7:0];
            end else if (w_step) begin
                case (w_sel)
                    SEL_HORA: r_hora <= w_hora_nx;
                    SEL_MIN:  r_min  <= w_min_nx;
                    SEL_SEG:  r_seg  <= w_seg_nx;
                    default:  ;
                endcase
            end
        end
    end

    assign hora_bcd = r_hora;
    assign min_bcd  = r_min;
    assign seg_bcd  = r_seg;
    assign escribir = r_escribir;

endmodule

// File: tb/tb_ajuste_valor_hora.sv
// Bench for ajuste_valor_hora: run-length reference model checked every cycle plus directed literal checks.
module tb_ajuste_valor_hora;
    localparam int HOLD = 4;
    localparam int REP  = 2;
`ifdef AUTO_REPEAT_EN
    localparam logic [7:0] SEG_AFTER = 8'h01;
`else
    localparam logic [7:0] SEG_AFTER = 8'h58;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_hora = 1'b0, a_min = 1'b0, a_seg = 1'b0;
    logic        btn_arriba = 1'b0, btn_abajo = 1'b0, cargar = 1'b0;
    logic [23:0] dato_in = '0;
    logic [7:0]  hora_bcd, min_bcd, seg_bcd;
    logic        escribir;

    ajuste_valor_hora #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst(rst), .a_hora(a_hora), .a_min(a_min), .a_seg(a_seg),
        .btn_arriba(btn_arriba), .btn_abajo(btn_abajo), .cargar(cargar), .dato_in(dato_in),
        .hora_bcd(hora_bcd), .min_bcd(min_bcd), .seg_bcd(seg_bcd), .escribir(escribir)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer clock arithmetic on decimal values.
    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] m_adj(input logic [7:0] v, input int mx, input bit up);
        int n;
        if (v[3:0] > 9 || v[7:4] > 9 || b2i(v) > mx)
            return up ? 8'h00 : i2b(mx);
        n = b2i(v);
        return up ? i2b((n + 1) % (mx + 1)) : i2b((n + mx) % (mx + 1));
    endfunction

    logic [7:0] m_h = 8'h00, m_m = 8'h00, m_s = 8'h00;
    bit m_wr = 0, m_pu = 0, m_pd = 0, m_armed = 0, m_dir = 0;
    int m_run = -1;
    int m_sel = 0;

    always @(posedge clk) begin
        automatic int  sel;
        automatic bit  one, rise, step;
        if (!rst) begin
            m_h = 8'h00; m_m = 8'h00; m_s = 8'h00; m_wr = 0;
            m_pu = 0; m_pd = 0; m_armed = 0; m_run = -1; m_sel = 0;
        end else begin
            sel  = a_hora ? 1 : a_min ? 2 : a_seg ? 3 : 0;
            one  = btn_arriba ^ btn_abajo;
            rise = one && m_armed && (btn_arriba ? !m_pu : !m_pd);
            step = 0;
            if (cargar) begin
                m_h = dato_in[23:16]; m_m = dato_in[15:8]; m_s = dato_in[7:0];
                m_run = -1;
            end else if (sel == 0 || !one) begin
                m_run = -1;
            end else if (rise) begin
                step  = 1;
                m_run = (sel != m_sel) ? -1 : 0;
                m_dir = btn_arriba;
            end else if (m_run >= 0 && sel == m_sel && btn_arriba == m_dir) begin
                m_run++;
`ifdef AUTO_REPEAT_EN
                if (m_run >= HOLD && (m_run - HOLD) % REP == 0) step = 1;
`endif
            end else begin
                m_run = -1;
            end
            if (step) begin
                case (sel)
                    1: m_h = m_adj(m_h, 23, btn_arriba);
                    2: m_m = m_adj(m_m, 59, btn_arriba);
                    3: m_s = m_adj(m_s, 59, btn_arriba);
                    default: ;
                endcase
            end
            m_wr    = cargar || step;
            m_pu    = btn_arriba;
            m_pd    = btn_abajo;
            m_armed = m_armed || (!btn_arriba && !btn_abajo);
            m_sel   = sel;
        end
        #1;
        check("model_hora", hora_bcd, m_h);
        check("model_min",  min_bcd,  m_m);
        check("model_seg",  seg_bcd,  m_s);
        check("model_escribir", escribir, m_wr);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [23:0] v);
        cargar = 1'b1; dato_in = v;
        tick(1);
        cargar = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic [7:0] seq [4];
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h58; exp_seq[1] = 8'h59; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;

        tick(2);
        check("rst_hora", hora_bcd, 8'h00);
        check("rst_escribir", escribir, 1'b0);
        rst = 1'b1;
        tick(1);

        // Wrap cases
        load(24'h230000);
        a_hora = 1'b1; tick(2);
        btn_arriba = 1'b1; tick(1);
        check("wrap_hora_up", hora_bcd, 8'h00);
        check("wrap_escribir", escribir, 1'b1);
        btn_arriba = 1'b0; tick(1);
        check("escribir_one_cycle", escribir, 1'b0);
        btn_abajo = 1'b1; tick(1);
        check("wrap_hora_dn", hora_bcd, 8'h23);
        btn_abajo = 1'b0; a_hora = 1'b0; a_min = 1'b1; tick(2);
        btn_abajo = 1'b1; tick(1);
        check("wrap_min_dn", min_bcd, 8'h59);
        btn_abajo = 1'b0; a_min = 1'b0; tick(1);

        // Hold for 10 cycles on seg
        a_seg = 1'b1;
        load(24'h000057);
        tick(1);
        btn_arriba = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (escribir) begin
                if (pulses < 4) seq[pulses] = seg_bcd;
                pulses++;
            end
        end
        btn_arriba = 1'b0; tick(1);
        check("hold_no_extra", escribir, 1'b0);
`ifdef AUTO_REPEAT_EN
        check("hold_pulses", pulses, 4);
        for (int k = 0; k < 4; k++) check("hold_seq", seq[k], exp_seq[k]);
`else
        check("hold_pulses", pulses, 1);
        check("hold_seq", seq[0], exp_seq[0]);
`endif
        check("hold_final", seg_bcd, SEG_AFTER);

        // Both buttons together
        btn_arriba = 1'b1; btn_abajo = 1'b1; tick(1);
        check("both_seg", seg_bcd, SEG_AFTER);
        check("both_escribir", escribir, 1'b0);
        btn_abajo = 1'b0; tick(2);
        check("both_release_one", seg_bcd, SEG_AFTER);
        check("both_release_wr", escribir, 1'b0);
        btn_arriba = 1'b0; tick(1);

        // Load beats a press on the same edge
        a_seg = 1'b0; a_hora = 1'b1; tick(2);
        cargar = 1'b1; dato_in = 24'h125930; btn_arriba = 1'b1; tick(1);
        cargar = 1'b0;
        check("load_hora", hora_bcd, 8'h12);
        check("load_min", min_bcd, 8'h59);
        check("load_seg", seg_bcd, 8'h30);
        check("load_escribir", escribir, 1'b1);
        tick(1);
        check("load_wr_drop", escribir, 1'b0);
        tick(4);
        check("load_no_inc", hora_bcd, 8'h12);
        btn_arriba = 1'b0; tick(1);

        // Non-BCD field contents
        a_hora = 1'b0; a_min = 1'b1;
        load(24'h007A00);
        btn_arriba = 1'b1; tick(1);
        check("bad_min_up", min_bcd, 8'h00);
        btn_arriba = 1'b0; tick(1);
        load(24'h007A00);
        btn_abajo = 1'b1; tick(1);
        check("bad_min_dn", min_bcd, 8'h59);
        btn_abajo = 1'b0; tick(1);
        a_min = 1'b0; a_hora = 1'b1;
        load(24'h240000);
        btn_abajo = 1'b1; tick(1);
        check("bad_hora_dn", hora_bcd, 8'h23);
        btn_abajo = 1'b0; a_hora = 1'b0; a_min = 1'b1; tick(2);

        // Reset while repeating, button still held afterwards
        load(24'h000000);
        btn_arriba = 1'b1; tick(7);
        rst = 1'b0; #1;
        check("rst_mid_hora", hora_bcd, 8'h00);
        check("rst_mid_min", min_bcd, 8'h00);
        check("rst_mid_seg", seg_bcd, 8'h00);
        check("rst_mid_wr", escribir, 1'b0);
        tick(2);
        rst = 1'b1; tick(4);
        check("rst_held_min", min_bcd, 8'h00);
        check("rst_held_wr", escribir, 1'b0);
        btn_arriba = 1'b0; tick(1);
        btn_arriba = 1'b1; tick(1);
        check("repress_min", min_bcd, 8'h01);
        check("repress_wr", escribir, 1'b1);
        btn_arriba = 1'b0; tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
